// File: rtl/unpacked_bank_store.sv
// Multi-bank storage on a 2-D unpacked array with a registered read port,
// per-bank occupancy counters and a sequential one-entry-per-cycle bank clear.
module unpacked_bank_store #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int BANKS = 4,
   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int BW = (BANKS > 2) ? $clog2(BANKS) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [BW-1:0]       wr_bank,
   input  logic [AW-1:0]       wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic                wr_err,
   input  logic                rd_en,
   input  logic [BW-1:0]       rd_bank,
   input  logic [AW-1:0]       rd_addr,
   output logic                rd_valid,
   output logic [WIDTH-1:0]    rd_data,
   output logic                rd_hit,
   output logic                rd_err,
   input  logic                clr_req,
   input  logic [BW-1:0]       clr_bank,
   output logic                busy,
   output logic                clr_done,
   output logic [BANKS*CW-1:0] occ
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [BW:0]   BANKS_L = (BW+1)'(BANKS);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PENULT  = AW'(DEPTH - 2);

   logic [WIDTH-1:0] mem     [BANKS][DEPTH];
   logic             valid_q [BANKS][DEPTH];
   logic [CW-1:0]    occ_q   [BANKS];

   state_t           state_q;
   logic [BW-1:0]    bank_q;
   logic [AW-1:0]    ptr_q;
   logic             clr_done_q;
   logic             wr_err_q;
   logic             rd_valid_q, rd_hit_q, rd_err_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_hit_d, rd_err_d;
   logic [WIDTH-1:0] rd_data_d;

   logic busy_w, wr_legal, wr_ok, rd_legal, rd_blocked, clr_start;

   assign busy_w     = (state_q == CLEAR);
   assign wr_legal   = ({1'b0, wr_bank} < BANKS_L) && ({1'b0, wr_addr} < DEPTH_L);
   assign wr_ok      = wr_en && wr_legal && !(busy_w && (wr_bank == bank_q));
   assign rd_legal   = ({1'b0, rd_bank} < BANKS_L) && ({1'b0, rd_addr} < DEPTH_L);
   assign rd_blocked = busy_w && (rd_bank == bank_q);
   assign clr_start  = (state_q == IDLE) && clr_req && ({1'b0, clr_bank} < BANKS_L);

   // Write-first forwarding: a same-edge write to the read address wins.
   always_comb begin
      rd_data_d = '0;
      rd_hit_d  = 1'b0;
      rd_err_d  = 1'b0;
      if (!rd_legal) begin
         rd_err_d = 1'b1;
      end else if (!rd_blocked) begin
         if (wr_ok && (wr_bank == rd_bank) && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
            rd_hit_d  = 1'b1;
         end else if (valid_q[rd_bank][rd_addr]) begin
            rd_data_d = mem[rd_bank][rd_addr];
            rd_hit_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)  mem[wr_bank][wr_addr] <= wr_data;
      if (busy_w) mem[bank_q][ptr_q]    <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < BANKS; b++)
            for (int d = 0; d < DEPTH; d++)
               valid_q[b][d] <= 1'b0;
      end else begin
         if (wr_ok)  valid_q[wr_bank][wr_addr] <= 1'b1;
         if (busy_w) valid_q[bank_q][ptr_q]    <= 1'b0;
      end
   end

   // Counters are zeroed when a clear starts; writes into that bank are blocked until it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < BANKS; b++) occ_q[b] <= '0;
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            if (clr_start && (clr_bank == BW'(b)))
               occ_q[b] <= '0;
            else if (wr_ok && (wr_bank == BW'(b)) && !valid_q[b][wr_addr])
               occ_q[b] <= occ_q[b] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bank_q     <= '0;
         ptr_q      <= '0;
         clr_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               clr_done_q <= 1'b0;
               if (clr_start) begin
                  bank_q  <= clr_bank;
                  ptr_q   <= '0;
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
               clr_done_q <= (ptr_q == PENULT);
               if (ptr_q == LAST) begin
                  ptr_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_hit_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         wr_err_q   <= wr_en && !wr_ok;
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
            rd_err_q  <= rd_err_d;
         end
      end
   end

   always_comb begin
      occ = '0;
      for (int b = 0; b < BANKS; b++) occ[b*CW +: CW] = occ_q[b];
   end

   assign wr_err   = wr_err_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_hit   = rd_hit_q;
   assign rd_err   = rd_err_q;
   assign busy     = busy_w;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_unpacked_bank_store.sv
// Directed bench for unpacked_bank_store with 3 banks of 8 x 8-bit entries.
module tb_unpacked_bank_store;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int BANKS = 3;
   localparam int AW = 3;
   localparam int BW = 2;
   localparam int CW = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                wr_en, rd_en, clr_req;
   logic [BW-1:0]       wr_bank, rd_bank, clr_bank;
   logic [AW-1:0]       wr_addr, rd_addr;
   logic [WIDTH-1:0]    wr_data;
   logic                wr_err, rd_valid, rd_hit, rd_err, busy, clr_done;
   logic [WIDTH-1:0]    rd_data;
   logic [BANKS*CW-1:0] occ;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unpacked_bank_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit), .rd_err(rd_err),
      .clr_req(clr_req), .clr_bank(clr_bank), .busy(busy), .clr_done(clr_done), .occ(occ)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [BW-1:0] b, input logic [AW-1:0] a);
      rd_en = 1'b1; rd_bank = b; rd_addr = a;
      step();
      rd_en = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [WIDTH-1:0] d, input logic h, input logic e);
      chk({tag, "_valid"}, rd_valid, 1'b1);
      chk({tag, "_data"}, rd_data, d);
      chk({tag, "_hit"}, rd_hit, h);
      chk({tag, "_err"}, rd_err, e);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
      wr_bank = '0; wr_addr = '0; wr_data = '0;
      rd_bank = '0; rd_addr = '0; clr_bank = '0;
      #3;
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_clr_done", clr_done, 1'b0);
      chk("rst_wr_err", wr_err, 1'b0);
      chk("rst_occ", occ, 12'h000);
      #9 rst_n = 1'b1;

      rd(2'd0, 3'd3);
      chk_rd("reset_read", 8'h00, 1'b0, 1'b0);
      chk("reset_read_occ", occ, 12'h000);

      wr(2'd1, 3'd2, 8'hA5);
      chk("wr_a5_err", wr_err, 1'b0);
      chk("wr_a5_occ", occ, 12'h010);
      rd(2'd1, 3'd2);
      chk_rd("readback_a5", 8'hA5, 1'b1, 1'b0);
      step();
      chk("hold_valid", rd_valid, 1'b0);
      chk("hold_data", rd_data, 8'hA5);
      chk("hold_hit", rd_hit, 1'b1);
      wr(2'd1, 3'd2, 8'h3C);
      chk("rewrite_occ", occ, 12'h010);
      rd(2'd1, 3'd2);
      chk_rd("readback_3c", 8'h3C, 1'b1, 1'b0);

      wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 3'd5; wr_data = 8'h77;
      rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 3'd5;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk_rd("collision", 8'h77, 1'b1, 1'b0);
      chk("collision_occ", occ, 12'h110);
      rd(2'd2, 3'd4);
      chk_rd("invalid_entry", 8'h00, 1'b0, 1'b0);

      for (int a = 0; a < DEPTH; a++) wr(2'd0, AW'(a), 8'h10 + 8'(a));
      chk("fill_occ", occ, 12'h118);
      rd(2'd0, 3'd7);
      chk_rd("fill_read", 8'h17, 1'b1, 1'b0);

      clr_req = 1'b1; clr_bank = 2'd0;
      step();
      clr_req = 1'b0;
      chk("clr_start_occ", occ, 12'h110);
      for (int c = 1; c <= DEPTH; c++) begin
         chk($sformatf("clr_busy_c%0d", c), busy, 1'b1);
         chk($sformatf("clr_done_c%0d", c), clr_done, (c == DEPTH) ? 1'b1 : 1'b0);
         if (c == 2) chk("clr_wr_blocked_err", wr_err, 1'b1);
         if (c == 3) begin
            chk("clr_other_wr_err", wr_err, 1'b0);
            chk("clr_other_wr_occ", occ, 12'h210);
         end
         if (c == 4) chk_rd("clr_read_blocked", 8'h00, 1'b0, 1'b0);
         wr_en = (c == 1) || (c == 2);
         wr_bank = (c == 1) ? 2'd0 : 2'd2;
         wr_addr = 3'd1;
         wr_data = (c == 1) ? 8'hEE : 8'h5A;
         rd_en = (c == 3);
         rd_bank = 2'd0; rd_addr = 3'd7;
         step();
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("clr_end_busy", busy, 1'b0);
      chk("clr_end_done", clr_done, 1'b0);
      chk("clr_end_occ", occ, 12'h210);
      rd(2'd0, 3'd1);
      chk_rd("after_clr_b0a1", 8'h00, 1'b0, 1'b0);
      rd(2'd0, 3'd7);
      chk_rd("after_clr_b0a7", 8'h00, 1'b0, 1'b0);
      rd(2'd2, 3'd1);
      chk_rd("after_clr_b2a1", 8'h5A, 1'b1, 1'b0);

      wr(2'd3, 3'd0, 8'h99);
      chk("oor_wr_err", wr_err, 1'b1);
      chk("oor_wr_occ", occ, 12'h210);
      rd(2'd3, 3'd0);
      chk_rd("oor_read", 8'h00, 1'b0, 1'b1);
      clr_req = 1'b1; clr_bank = 2'd3;
      step();
      clr_req = 1'b0;
      chk("oor_clr_ignored", busy, 1'b0);
      step();
      chk("wr_err_one_cycle", wr_err, 1'b0);

      clr_req = 1'b1; clr_bank = 2'd1;
      step();
      clr_req = 1'b0;
      step(); step(); step();
      chk("midclr_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #2;
      chk("midclr_busy", busy, 1'b0);
      chk("midclr_occ", occ, 12'h000);
      chk("midclr_rd_valid", rd_valid, 1'b0);
      chk("midclr_rd_err", rd_err, 1'b0);
      rst_n = 1'b1;
      rd(2'd2, 3'd5);
      chk_rd("post_rst_b2a5", 8'h00, 1'b0, 1'b0);
      rd(2'd1, 3'd2);
      chk_rd("post_rst_b1a2", 8'h00, 1'b0, 1'b0);
      rd(2'd2, 3'd1);
      chk_rd("post_rst_b2a1", 8'h00, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
